// File: rtl/dmem_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines sitting between the core
// data port and the DRAM user interface. Define DMEM_CACHE_STATS_EN to add hit/miss counters.
module dmem_cache #(
    parameter int CACHE_LINES    = 64,
    parameter int APP_ADDR_WIDTH = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      i_rst,
    input  logic                      i_dmem_ren,
    input  logic [3:0]                i_dmem_wen,
    input  logic [31:0]               i_dmem_addr,
    input  logic [31:0]               i_dmem_data,
    output logic [31:0]               o_dmem_data,
    output logic                      o_dmem_stall,
    output logic                      o_dram_ren,
    output logic                      o_dram_wen,
    output logic [APP_ADDR_WIDTH-2:0] o_dram_addr,
    output logic [APP_DATA_WIDTH-1:0] o_dram_data,
    output logic [APP_MASK_WIDTH-1:0] o_dram_mask,
    output logic                      o_dram_busy,
    input  logic                      i_dram_init_calib_complete,
    input  logic [APP_DATA_WIDTH-1:0] i_dram_data,
    input  logic                      i_dram_data_valid,
    input  logic                      i_dram_busy
`ifdef DMEM_CACHE_STATS_EN
    ,
    output logic [31:0]               o_hit_count,
    output logic [31:0]               o_miss_count
`endif
);
    localparam int IDX_W  = $clog2(CACHE_LINES);
    localparam int LINE_W = APP_ADDR_WIDTH - 4;
    localparam int TAG_W  = LINE_W - IDX_W;

    localparam logic [2:0] S_CALIB     = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_WB        = 3'd2;
    localparam logic [2:0] S_FILL      = 3'd3;
    localparam logic [2:0] S_FILL_WAIT = 3'd4;

    logic [2:0]                r_state;
    logic [CACHE_LINES-1:0]    r_valid;
    logic [CACHE_LINES-1:0]    r_dirty;
    logic [TAG_W-1:0]          r_tag_mem  [CACHE_LINES];
    logic [APP_DATA_WIDTH-1:0] r_line_mem [CACHE_LINES];
    logic [LINE_W-1:0]         r_wb_line_addr;
    logic [LINE_W-1:0]         r_fill_line_addr;
    logic [APP_DATA_WIDTH-1:0] r_wb_data;

    logic [1:0]                w_offset;
    logic [IDX_W-1:0]          w_index;
    logic [TAG_W-1:0]          w_tag;
    logic [IDX_W-1:0]          w_fill_index;
    logic                      w_request;
    logic                      w_write;
    logic                      w_hit;
    logic                      w_idle;
    logic [APP_DATA_WIDTH-1:0] w_line;
    logic [APP_DATA_WIDTH-1:0] w_merged;
    logic                      w_unused_addr_bits;

    assign w_offset     = i_dmem_addr[3:2];
    assign w_index      = i_dmem_addr[4 +: IDX_W];
    assign w_tag        = i_dmem_addr[APP_ADDR_WIDTH-1 -: TAG_W];
    assign w_fill_index = r_fill_line_addr[IDX_W-1:0];
    assign w_line       = r_line_mem[w_index];
    assign w_write      = (i_dmem_wen != 4'b0000);
    assign w_request    = i_dmem_ren || w_write;
    assign w_hit        = r_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    assign w_idle       = (r_state == S_IDLE);

    assign w_unused_addr_bits = &{1'b0, i_dmem_addr[31:APP_ADDR_WIDTH], i_dmem_addr[1:0]};

    // Byte-granular merge of the core write word into the addressed line slot.
    genvar gi;
    generate
        for (gi = 0; gi < APP_MASK_WIDTH; gi++) begin : g_merge
            assign w_merged[gi*8 +: 8] = ((w_offset == 2'(gi / 4)) && i_dmem_wen[gi % 4])
                                         ? i_dmem_data[(gi % 4)*8 +: 8]
                                         : w_line[gi*8 +: 8];
        end
    endgenerate

    assign o_dmem_data  = (w_idle && w_hit && i_dmem_ren) ? w_line[{w_offset, 5'b00000} +: 32] : 32'd0;
    assign o_dmem_stall = !w_idle || (w_request && !w_hit);
    assign o_dram_wen   = (r_state == S_WB) && !i_dram_busy;
    assign o_dram_ren   = (r_state == S_FILL) && !i_dram_busy;
    assign o_dram_addr  = {((r_state == S_WB) ? r_wb_line_addr : r_fill_line_addr), 3'b000};
    assign o_dram_data  = r_wb_data;
    assign o_dram_mask  = '0;
    assign o_dram_busy  = 1'b0;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= S_CALIB;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            case (r_state)
                S_CALIB: begin
                    if (i_dram_init_calib_complete) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (w_request) begin
                        if (w_hit) begin
                            if (w_write) r_dirty[w_index] <= 1'b1;
                        end else if (r_valid[w_index] && r_dirty[w_index]) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (!i_dram_busy) r_state <= S_FILL;
                end
                S_FILL: begin
                    if (!i_dram_busy) r_state <= S_FILL_WAIT;
                end
                S_FILL_WAIT: begin
                    if (i_dram_data_valid) begin
                        r_valid[w_fill_index] <= 1'b1;
                        r_dirty[w_fill_index] <= 1'b0;
                        r_state               <= S_IDLE;
                    end
                end
                default: r_state <= S_CALIB;
            endcase
        end
    end

    // Line/tag storage and miss bookkeeping carry no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (w_idle && w_request && !w_hit) begin
            r_fill_line_addr <= {w_tag, w_index};
            r_wb_line_addr   <= {r_tag_mem[w_index], w_index};
            r_wb_data        <= w_line;
        end
        if (!i_rst && w_idle && w_request && w_hit && w_write) begin
            r_line_mem[w_index] <= w_merged;
        end else if (!i_rst && (r_state == S_FILL_WAIT) && i_dram_data_valid) begin
            r_line_mem[w_fill_index] <= i_dram_data;
            r_tag_mem[w_fill_index]  <= r_fill_line_addr[LINE_W-1 -: TAG_W];
        end
    end

`ifdef DMEM_CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_hit_count  <= 32'd0;
            o_miss_count <= 32'd0;
        end else if (w_idle && w_request) begin
            if (w_hit) o_hit_count  <= o_hit_count + 32'd1;
            else       o_miss_count <= o_miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_cache.sv
// Directed plus randomized bench for dmem_cache: a flat word-memory reference (core view and DRAM
// view) plus per-index residency tracking predicts data, strobes, addresses and miss timing.
module tb_dmem_cache;
    localparam int LINES = 64;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_dmem_ren;
    logic [3:0]   i_dmem_wen;
    logic [31:0]  i_dmem_addr;
    logic [31:0]  i_dmem_data;
    logic [31:0]  o_dmem_data;
    logic         o_dmem_stall;
    logic         o_dram_ren;
    logic         o_dram_wen;
    logic [26:0]  o_dram_addr;
    logic [127:0] o_dram_data;
    logic [15:0]  o_dram_mask;
    logic         o_dram_busy;
    logic         i_dram_init_calib_complete;
    logic [127:0] i_dram_data;
    logic         i_dram_data_valid;
    logic         i_dram_busy;
`ifdef DMEM_CACHE_STATS_EN
    logic [31:0]  o_hit_count;
    logic [31:0]  o_miss_count;
`endif

    always #5 clk = ~clk;

    dmem_cache #(
        .CACHE_LINES(LINES), .APP_ADDR_WIDTH(28), .APP_DATA_WIDTH(128), .APP_MASK_WIDTH(16)
    ) dut (
        .clk(clk), .i_rst(i_rst),
        .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen), .i_dmem_addr(i_dmem_addr),
        .i_dmem_data(i_dmem_data), .o_dmem_data(o_dmem_data), .o_dmem_stall(o_dmem_stall),
        .o_dram_ren(o_dram_ren), .o_dram_wen(o_dram_wen), .o_dram_addr(o_dram_addr),
        .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask), .o_dram_busy(o_dram_busy),
        .i_dram_init_calib_complete(i_dram_init_calib_complete), .i_dram_data(i_dram_data),
        .i_dram_data_valid(i_dram_data_valid), .i_dram_busy(i_dram_busy)
`ifdef DMEM_CACHE_STATS_EN
        , .o_hit_count(o_hit_count), .o_miss_count(o_miss_count)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] gmem [int];   // what the core should observe, by word address
    logic [31:0] bmem [int];   // what DRAM holds, by word address
    bit          mvalid [LINES];
    bit          mdirty [LINES];
    int          mtag   [LINES];

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int wa);
        return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction
    function automatic logic [31:0] gword(input int wa);
        if (gmem.exists(wa)) return gmem[wa];
        return init_word(wa);
    endfunction
    function automatic logic [31:0] bword(input int wa);
        if (bmem.exists(wa)) return bmem[wa];
        return init_word(wa);
    endfunction
    function automatic logic [127:0] gline(input int la);
        logic [127:0] l;
        for (int n = 0; n < 4; n++) l[n*32 +: 32] = gword(la*4 + n);
        return l;
    endfunction
    function automatic logic [127:0] bline(input int la);
        logic [127:0] l;
        for (int n = 0; n < 4; n++) l[n*32 +: 32] = bword(la*4 + n);
        return l;
    endfunction
    function automatic int line_of(input logic [31:0] a);
        return int'(a[27:4]);
    endfunction

    // A reset loses every cached line, so the core view falls back to DRAM contents.
    task automatic model_reset();
        gmem.delete();
        foreach (bmem[k]) gmem[k] = bmem[k];
        for (int i = 0; i < LINES; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        i_dmem_ren = 1'b0; i_dmem_wen = 4'b0000; i_dram_busy = 1'b0; i_dram_data_valid = 1'b0;
    endtask

    task automatic access(input logic ren, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input int busy_n, input int lat);
        int idx, tg, la, vla, wa, c, wb_c, rd_c, nwb, nrd, first_c;
        bit hit, dv;
        logic [31:0] w;
        idx = (line_of(addr) % LINES);
        tg  = line_of(addr) / LINES;
        la  = line_of(addr);
        wa  = la*4 + int'(addr[3:2]);
        hit = mvalid[idx] && (mtag[idx] == tg);
        dv  = !hit && mvalid[idx] && mdirty[idx];
        vla = mtag[idx]*LINES + idx;
        @(negedge clk);
        i_dmem_ren = ren; i_dmem_wen = wen; i_dmem_addr = addr; i_dmem_data = wdata;
        i_dram_busy = (busy_n > 0); i_dram_data_valid = 1'b0;
        i_dram_data = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("entry_stall", o_dmem_stall, !hit);
        if (!hit) begin
            c = 0; wb_c = -1; rd_c = -1; nwb = 0; nrd = 0; first_c = busy_n + 1;
            while (o_dmem_stall && c < 100) begin
                chk("strobe_while_busy", i_dram_busy & (o_dram_ren | o_dram_wen), 0);
                if (o_dram_wen) begin
                    nwb++;
                    wb_c = c;
                    chk("wb_cycle", c, first_c);
                    chk("wb_addr", o_dram_addr, 27'(vla*8));
                    chk("wb_data", o_dram_data, gline(vla));
                    chk("wb_mask", o_dram_mask, 0);
                    for (int n = 0; n < 4; n++) bmem[vla*4 + n] = o_dram_data[n*32 +: 32];
                end
                if (o_dram_ren) begin
                    nrd++;
                    rd_c = c;
                    chk("rd_cycle", c, dv ? wb_c + 1 : first_c);
                    chk("rd_addr", o_dram_addr, 27'(la*8));
                end
                @(negedge clk);
                c++;
                i_dram_busy       = (c <= busy_n);
                i_dram_data_valid = (rd_c >= 0) && (c == rd_c + lat);
                i_dram_data       = i_dram_data_valid ? bline(la) : {$urandom, $urandom, $urandom, $urandom};
                #1;
            end
            chk("miss_penalty", c, rd_c + lat + 1);
            chk("replay_stall", o_dmem_stall, 0);
            chk("wb_count", nwb, dv);
            chk("rd_count", nrd, 1);
            mvalid[idx] = 1'b1; mtag[idx] = tg; mdirty[idx] = 1'b0;
        end
        if (wen != 4'b0000) begin
            w = gword(wa);
            for (int b = 0; b < 4; b++) if (wen[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
            gmem[wa] = w;
            mdirty[idx] = 1'b1;
        end else begin
            chk("rdata", o_dmem_data, gword(wa));
        end
        @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  wen;
        logic        ren;
        i_rst = 1'b1; i_dram_init_calib_complete = 1'b0;
        i_dmem_ren = 1'b0; i_dmem_wen = 4'b0000; i_dmem_addr = 32'd0; i_dmem_data = 32'd0;
        i_dram_data = '0; i_dram_data_valid = 1'b0; i_dram_busy = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_stall", o_dmem_stall, 1);
        chk("rst_dram_ren", o_dram_ren, 0);
        chk("rst_dram_wen", o_dram_wen, 0);
        chk("rst_dmem_data", o_dmem_data, 0);
        chk("dram_busy_out", o_dram_busy, 0);
`ifdef DMEM_CACHE_STATS_EN
        chk("rst_hit_count", o_hit_count, 0);
        chk("rst_miss_count", o_miss_count, 0);
`endif
        @(negedge clk);
        i_rst = 1'b0; i_dmem_ren = 1'b1; i_dmem_addr = 32'h100;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("calib_stall", o_dmem_stall, 1);
            chk("calib_dram_ren", o_dram_ren, 0);
            @(negedge clk);
        end
        i_dram_init_calib_complete = 1'b1;

        access(1'b1, 4'b0000, 32'h100, 32'h0, 0, 3);
        access(1'b0, 4'b0011, 32'h104, 32'hDEADBEEF, 0, 1);
        access(1'b1, 4'b0000, 32'h104, 32'h0, 0, 1);
        access(1'b0, 4'b1111, 32'h000, 32'h12345678, 0, 2);
        access(1'b1, 4'b0000, 32'h400, 32'h0, 0, 2);
        access(1'b1, 4'b1010, 32'h408, 32'hCAFEF00D, 0, 1);
        access(1'b1, 4'b0000, 32'h000, 32'h0, 5, 2);

        // Reset while the refill is outstanding; late data must be dropped.
        @(negedge clk);
        i_dmem_ren = 1'b1; i_dmem_wen = 4'b0000; i_dmem_addr = 32'h800; i_dram_busy = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (o_dram_ren) break;
            @(negedge clk);
        end
        chk("rst_test_ren_seen", o_dram_ren, 1);
        @(negedge clk);
        i_rst = 1'b1; i_dmem_ren = 1'b0;
        @(negedge clk);
        i_rst = 1'b0; i_dram_data_valid = 1'b1; i_dram_data = {4{32'hBAD0BAD0}};
        #1;
        chk("post_rst_stall", o_dmem_stall, 1);
        chk("post_rst_dram_ren", o_dram_ren, 0);
        @(negedge clk);
        i_dram_data_valid = 1'b0;
        model_reset();

        access(1'b1, 4'b0000, 32'h800, 32'h0, 0, 4);
        access(1'b1, 4'b0000, 32'h804, 32'h0, 0, 1);
        access(1'b1, 4'b0000, 32'h808, 32'h0, 0, 1);
        access(1'b1, 4'b0000, 32'h80C, 32'h0, 0, 1);
        #1;
`ifdef DMEM_CACHE_STATS_EN
        chk("stats_hit_count", o_hit_count, 4);
        chk("stats_miss_count", o_miss_count, 1);
`endif

        for (int t = 0; t < 200; t++) begin
            ren = 1'(($urandom_range(0, 1)));
            wen = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            if (!ren && wen == 4'b0000) ren = 1'b1;
            a = ($urandom & 32'hF000_0000) | (32'($urandom_range(0, 3)) << 10)
              | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, 3)) << 2) | ($urandom & 32'h3);
            access(ren, wen, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 6));
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dmem_cache.md
Name: dmem_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's data-memory port and the DRAM user interface.
- Data-memory hits complete with no stall.
- Misses evict a dirty victim, if present, with one 128-bit DRAM write, then refill with one 128-bit DRAM read.
- DRAM-side signalling matches the DRAM model: read/write strobes, busy, data_valid, and a byte mask where 1 means the byte is not written.

Parameters:
- CACHE_LINES, 64: number of 16-byte lines; must be a power of two, at least 2.
- APP_ADDR_WIDTH, 28: DRAM byte-address width; the DRAM column address is APP_ADDR_WIDTH-1 bits.
- APP_DATA_WIDTH, 128: line width in bits; fixed at 128.
- APP_MASK_WIDTH, 16: DRAM byte-mask width; equals APP_DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_dmem_ren  in  1  word read request
- i_dmem_wen  in  4  byte write enables; non-zero means write, and write wins over read
- i_dmem_addr  in  32  byte address; bits [1:0] ignored
- i_dmem_data  in  32  write data
- o_dmem_data  out  32  read data; combinational, valid in a non-stalled cycle with ren=1
- o_dmem_stall  out  1  core must hold its request stable while this is 1
- o_dram_ren  out  1  DRAM read strobe
- o_dram_wen  out  1  DRAM write strobe
- o_dram_addr  out  APP_ADDR_WIDTH-1  line column address {byte_addr[APP_ADDR_WIDTH-1:4],3'b000}
- o_dram_data  out  128  writeback line
- o_dram_mask  out  16  always 0 (full-line write)
- o_dram_busy  out  1  always 0; the cache always accepts read data
- i_dram_init_calib_complete  in  1  DRAM calibration complete
- i_dram_data  in  128  DRAM read data
- i_dram_data_valid  in  1  i_dram_data is valid
- i_dram_busy  in  1  DRAM cannot accept a command this cycle

Behaviour:
- Address split:
  - offset = addr[3:2] selects word = line[offset*32 +: 32].
  - index = addr[4 +: log2(CACHE_LINES)].
  - tag = remaining bits up to APP_ADDR_WIDTH-1.
- Storage: per line a valid bit, a dirty bit, a tag and 128 data bits.
- Reset: valid and dirty bits all cleared; state CALIB; o_dram_ren=0, o_dram_wen=0, o_dmem_data=0, o_dmem_stall=1. Data and tag arrays are not reset.
- hit = valid[index] && tag matches. A request is ren || wen!=0.
- o_dmem_stall = (state!=IDLE) || (request && !hit).
- CALIB → IDLE when i_dram_init_calib_complete=1.
- In IDLE:
  - Read hit: o_dmem_data is the selected word in the same cycle.
  - Write hit: merge the enabled bytes into the line at the clock edge; set dirty.
  - Both hit cases have zero stall cycles.
  - Miss with victim valid and dirty → WB; latch the victim line and address {victim_tag,index}.
  - Miss otherwise → FILL; latch the request line address.
- WB: o_dram_wen = !i_dram_busy. When !i_dram_busy → FILL.
- FILL: o_dram_ren = !i_dram_busy. When !i_dram_busy → FILL_WAIT.
- FILL_WAIT: on i_dram_data_valid, write the line, set valid, clear dirty, update the tag, → IDLE.
  - The held core request then replays as a hit in the next cycle.
  - Miss penalty with no busy: 2 cycles plus DRAM read latency, plus 1 cycle for a dirty eviction.
- DRAM strobes are 1-cycle pulses and are never asserted while i_dram_busy=1.
- ren and wen together: treated as a write.
- Request dropped while stalled in WB/FILL/FILL_WAIT: the transaction still completes and the line is installed; nothing is merged.
- Reset asserted mid-transaction: immediate return to CALIB with all lines invalid; in-flight DRAM data is ignored.
- Stray i_dram_data_valid outside FILL_WAIT: ignored.

Optional Feature:
- Macro DMEM_CACHE_STATS_EN.
- Defined:
  - Adds outputs o_hit_count (32 bits) and o_miss_count (32 bits), both reset to 0.
  - o_hit_count increments on every IDLE cycle with a request and a hit, including replays after a refill.
  - o_miss_count increments on each IDLE→WB or IDLE→FILL transition.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then calib_complete after 10 cycles → stall=1 until then; first read of 0x100 → one FILL with o_dram_addr=0x100>>1 column form (0x80); data returned → replayed read has stall=0, data = word 0 of the line.
- Write 0xDEADBEEF with wen=4'b0011 to 0x104 (cached) → no stall; read 0x104 → low half 0xBEEF, upper bytes unchanged.
- Dirty line at index 0, then read an address with a different tag and the same index → o_dram_wen pulse with mask=0 and the old line and address, then o_dram_ren, then the new line is installed.
- Hold i_dram_busy=1 for 5 cycles during WB → no strobe while busy; strobe on the first non-busy cycle; stall held throughout.
- Assert i_rst during FILL_WAIT, then deliver data_valid → data ignored; re-read the same address misses again.
- With DMEM_CACHE_STATS_EN: 1 miss followed by 3 hits to the same line → o_miss_count=1, o_hit_count=4 (replay counted).
